// File: rtl/fb_capture_ctrl.sv
// rtl/fb_capture_ctrl.sv - camera-to-frame-buffer write sequencer with frame admission and freeze control
//
// Purpose:
//   Gates the ov7670 capture write port onto frame buffer port A so that only
//   whole, frame-aligned images land in the buffer. A completed frame can be
//   frozen (HOLD) for the display readers, either on request or automatically
//   in single-shot mode. Good/short frame pulses and a good-frame counter are
//   provided for status LEDs.
//
// Ports:
//   clk, rst          system clock (port A clock), async active-high reset
//   config_done       camera register setup finished (level)
//   vsync             raw camera vsync, asynchronous to clk
//   cap_we/addr/data  write port from the capture block
//   freeze_req        pulse: freeze after the current frame completes
//   run_req           pulse: resume capture
//   single_shot       level: freeze automatically after each good frame
//   fb_we/addr/data   registered, gated write port to the frame buffer
//   frame_done        pulse at end of every good frame
//   frame_err         pulse at end of a short or over-long frame
//   frame_cnt         wrapping count of good frames
//   img_valid         buffer holds a complete frozen frame
//   state             0 IDLE, 1 SYNC, 2 CAPTURE, 3 HOLD

module fb_capture_ctrl #(
  parameter int c_img_pxls    = 4800,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 16,
  parameter int c_hold_frames = 0,
  parameter int c_frm_cnt_w   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     config_done,
  input  logic                     vsync,
  input  logic                     cap_we,
  input  logic [c_nb_img_pxls-1:0] cap_addr,
  input  logic [c_nb_buf-1:0]      cap_data,
  input  logic                     freeze_req,
  input  logic                     run_req,
  input  logic                     single_shot,
  output logic                     fb_we,
  output logic [c_nb_img_pxls-1:0] fb_addr,
  output logic [c_nb_buf-1:0]      fb_data,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [c_frm_cnt_w-1:0]   frame_cnt,
  output logic                     img_valid,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_sync    = 2'd1,
    st_capture = 2'd2,
    st_hold    = 2'd3
  } state_t;

  // One extra bit so an over-long frame cannot alias onto c_img_pxls.
  localparam logic [c_nb_img_pxls:0] c_img_cnt  = (c_nb_img_pxls+1)'(c_img_pxls);
  localparam logic [7:0]             c_hold_lim = 8'(c_hold_frames);

  state_t cur_st;
  state_t nxt_st;

  logic vs_meta;
  logic vs_sync;
  logic vs_dly;
  logic fb_evt;

  logic                   accept;
  logic [c_nb_img_pxls:0] pix_cnt;
  logic [c_nb_img_pxls:0] pix_inc;
  logic                   frame_full;

  logic       freeze_pend;
  logic       pend_nxt;
  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;
  logic       done_nxt;
  logic       err_nxt;

  // vsync crossing: two flops for metastability, a third for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_dly  <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_dly  <= vs_sync;
    end
  end

  // Frame boundary is the synchronized falling edge of vsync.
  assign fb_evt = vs_dly & ~vs_sync;

  // config_done also gates the write so a dropped configuration stops writes
  // on the very cycle the FSM heads back to IDLE.
  assign accept = cap_we & config_done & (cur_st == st_capture) &
                  ({1'b0, cap_addr} < c_img_cnt);

  // A write coinciding with fb_evt belongs to the frame being closed, so the
  // end-of-frame evaluation uses the post-increment count.
  assign pix_inc    = (accept && (pix_cnt != '1)) ? pix_cnt + 1'b1 : pix_cnt;
  assign frame_full = (pix_inc == c_img_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st <= st_idle;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st   = cur_st;
    pend_nxt = freeze_pend;
    hold_nxt = hold_cnt;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (!config_done) begin
      nxt_st   = st_idle;
      pend_nxt = 1'b0;
    end else begin
      case (cur_st)
        st_idle: begin
          pend_nxt = 1'b0;
          nxt_st   = st_sync;
        end
        st_sync: begin
          // run_req wins over a simultaneous freeze_req.
          if (run_req) begin
            pend_nxt = 1'b0;
          end else if (freeze_req) begin
            pend_nxt = 1'b1;
          end
          if (fb_evt) begin
            nxt_st = st_capture;
          end
        end
        st_capture: begin
          if (run_req) begin
            pend_nxt = 1'b0;
          end else if (freeze_req) begin
            pend_nxt = 1'b1;
          end
          if (fb_evt) begin
            if (frame_full) begin
              done_nxt = 1'b1;
              if (pend_nxt || single_shot) begin
                nxt_st   = st_hold;
                pend_nxt = 1'b0;
                hold_nxt = '0;
              end
            end else begin
              // A failed frame keeps any pending freeze for the next good one.
              err_nxt = 1'b1;
            end
          end
        end
        st_hold: begin
          pend_nxt = 1'b0;
          if (run_req) begin
            nxt_st = st_sync;
          end else if (fb_evt) begin
            hold_nxt = hold_cnt + 1'b1;
            if ((c_hold_frames != 0) && (hold_nxt == c_hold_lim)) begin
              nxt_st = st_sync;
            end
          end
        end
        default: begin
          nxt_st = st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt     <= '0;
      freeze_pend <= 1'b0;
      hold_cnt    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      img_valid   <= 1'b0;
    end else begin
      pix_cnt     <= fb_evt ? '0 : pix_inc;
      freeze_pend <= pend_nxt;
      hold_cnt    <= hold_nxt;
      frame_done  <= done_nxt;
      frame_err   <= err_nxt;
      if (done_nxt) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      // Tracks the state register so it drops the cycle HOLD is left.
      img_valid   <= (nxt_st == st_hold);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we   <= accept;
      fb_addr <= cap_addr;
      fb_data <= cap_data;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// tb/tb_fb_capture_ctrl.sv - randomized self-checking bench for fb_capture_ctrl

module tb_fb_capture_ctrl;

  localparam int IMG   = 4800;
  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int HOLDF = 3;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          config_done = 1'b0;
  logic          vsync = 1'b0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_data = '0;
  logic          freeze_req = 1'b0;
  logic          run_req = 1'b0;
  logic          single_shot = 1'b0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          frame_done;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;
  logic          img_valid;
  logic [1:0]    state;

  fb_capture_ctrl #(
    .c_img_pxls(IMG), .c_nb_img_pxls(AW), .c_nb_buf(DW),
    .c_hold_frames(HOLDF), .c_frm_cnt_w(CW)
  ) dut (
    .clk(clk), .rst(rst), .config_done(config_done), .vsync(vsync),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
    .freeze_req(freeze_req), .run_req(run_req), .single_shot(single_shot),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .img_valid(img_valid), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: 0 IDLE, 1 SYNC, 2 CAPTURE, 3 HOLD
  int            m_state, m_cnt, pix, frame_pix, hold;
  bit            m_we, m_done, m_err, m_valid, pend, evt, acc;
  bit [2:0]      hv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_cnt = 0; pix = 0; hold = 0; pend = 0; hv = '0;
        m_we = 0; m_done = 0; m_err = 0; m_valid = 0; m_addr = '0; m_data = '0;
      end else begin
        // vsync fall seen through the synchronizer takes effect 3 edges after sampling
        evt = hv[2] && !hv[1];
        hv  = {hv[1:0], vsync};
        acc = cap_we && config_done && (m_state == 2) && (cap_addr < IMG);
        m_we = acc; m_addr = cap_addr; m_data = cap_data;
        m_done = 0; m_err = 0;
        if (acc) pix++;
        frame_pix = pix;
        if (evt) pix = 0;
        if (!config_done) begin
          m_state = 0; pend = 0;
        end else if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 3) begin
          pend = 0;
          if (run_req) m_state = 1;
          else if (evt) begin
            hold++;
            if (HOLDF != 0 && hold == HOLDF) m_state = 1;
          end
        end else begin
          if (run_req) pend = 0;
          else if (freeze_req) pend = 1;
          if (evt && m_state == 1) m_state = 2;
          else if (evt) begin
            if (frame_pix == IMG) begin
              m_done = 1;
              m_cnt = (m_cnt + 1) % (1 << CW);
              if (pend || single_shot) begin
                m_state = 3; pend = 0; hold = 0;
              end
            end else begin
              m_err = 1;
            end
          end
        end
        m_valid = (m_state == 3);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("state", 32'(state), 32'(m_state));
        chk("fb_we", 32'(fb_we), 32'(m_we));
        chk("fb_addr", 32'(fb_addr), 32'(m_addr));
        chk("fb_data", 32'(fb_data), 32'(m_data));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("img_valid", 32'(img_valid), 32'(m_valid));
        we_cnt   += int'(fb_we);
        done_cnt += int'(frame_done);
        err_cnt  += int'(frame_err);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic vs_edge();
    vsync = 1'b1;
    repeat (4) cyc();
    vsync = 1'b0;
    repeat (5) cyc();
  endtask

  // n in-range writes at addr 0..n-1 with random gaps, then oor writes beyond
  // the image. coinc places the frame boundary on the last in-range write.
  task automatic frame(input int n, input int oor, input int frz_at, input int run_at, input bit coinc);
    for (int i = 0; i < n; i++) begin
      if (!coinc || i < n - 8) begin
        while ($urandom_range(15) == 0) begin
          cap_we = 1'b0;
          cap_data = DW'($urandom);
          cyc();
        end
      end
      cap_we = 1'b1;
      cap_addr = AW'(i);
      cap_data = DW'($urandom);
      freeze_req = (i == frz_at);
      run_req = (i == run_at);
      if (coinc && i == n - 6) vsync = 1'b1;
      if (coinc && i == n - 3) vsync = 1'b0;
      cyc();
      freeze_req = 1'b0;
      run_req = 1'b0;
    end
    for (int j = 0; j < oor; j++) begin
      cap_we = 1'b1;
      cap_addr = AW'(IMG + j);
      cap_data = DW'($urandom);
      cyc();
    end
    cap_we = 1'b0;
    if (coinc) repeat (4) cyc();
    else vs_edge();
  endtask

  int we0, dn0, er0, n, kind;

  initial begin
    chk_en = 1'b1;
    repeat (3) cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_img_valid", 32'(img_valid), 0);
    rst = 1'b0;
    cyc();
    chk("idle_wait", 32'(state), 0);
    config_done = 1'b1;
    cyc();
    chk("to_sync", 32'(state), 1);
    vs_edge();
    chk("to_capture", 32'(state), 2);

    // first full frame in continuous mode
    we0 = we_cnt; dn0 = done_cnt;
    frame(IMG, 0, -1, -1, 1'b0);
    chk("f1_we_count", 32'(we_cnt - we0), IMG);
    chk("f1_done_count", 32'(done_cnt - dn0), 1);
    chk("f1_frame_cnt", 32'(frame_cnt), 1);
    chk("f1_state", 32'(state), 2);

    // single-shot: boundary lands on the final write
    single_shot = 1'b1;
    frame(IMG, 0, -1, -1, 1'b1);
    chk("ss_state", 32'(state), 3);
    chk("ss_img_valid", 32'(img_valid), 1);
    chk("ss_frame_cnt", 32'(frame_cnt), 2);
    we0 = we_cnt;
    frame(IMG, 0, -1, -1, 1'b0);
    chk("hold_no_we", 32'(we_cnt - we0), 0);
    chk("hold_frame_cnt", 32'(frame_cnt), 2);
    run_req = 1'b1;
    cyc();
    run_req = 1'b0;
    chk("run_state", 32'(state), 1);
    chk("run_img_valid", 32'(img_valid), 0);
    single_shot = 1'b0;

    // short frame plus out-of-range writes
    vs_edge();
    we0 = we_cnt; er0 = err_cnt;
    frame(4000, 100, -1, -1, 1'b0);
    chk("short_err", 32'(err_cnt - er0), 1);
    chk("short_we", 32'(we_cnt - we0), 4000);
    chk("short_frame_cnt", 32'(frame_cnt), 2);

    // freeze mid-frame, then HOLD lasts HOLDF boundaries
    frame(IMG, 0, 2000, -1, 1'b0);
    chk("frz_state", 32'(state), 3);
    chk("frz_frame_cnt", 32'(frame_cnt), 3);
    vs_edge();
    vs_edge();
    chk("hold2_state", 32'(state), 3);
    vs_edge();
    chk("hold3_state", 32'(state), 1);

    // run_req and freeze_req together: run wins
    vs_edge();
    frame(IMG, 0, 1000, 1000, 1'b0);
    chk("runwin_state", 32'(state), 2);
    chk("runwin_frame_cnt", 32'(frame_cnt), 4);

    // config_done dropped mid-capture
    for (int i = 0; i < 50; i++) begin
      cap_we = 1'b1;
      cap_addr = AW'(i);
      if (i == 40) config_done = 1'b0;
      cyc();
      if (i == 40) break;
    end
    chk("cfgdrop_state", 32'(state), 0);
    chk("cfgdrop_fb_we", 32'(fb_we), 0);
    chk("cfgdrop_frame_cnt", 32'(frame_cnt), 4);
    cap_we = 1'b0;
    config_done = 1'b1;
    cyc();
    vs_edge();
    chk("recap_state", 32'(state), 2);

    // asynchronous reset mid-capture
    for (int i = 0; i < 100; i++) begin
      cap_we = 1'b1;
      cap_addr = AW'(i);
      cap_data = DW'($urandom);
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_fb_we", 32'(fb_we), 0);
    chk("arst_fb_addr", 32'(fb_addr), 0);
    chk("arst_fb_data", 32'(fb_data), 0);
    chk("arst_frame_cnt", 32'(frame_cnt), 0);
    chk("arst_img_valid", 32'(img_valid), 0);
    cyc();
    rst = 1'b0;
    cap_we = 1'b0;
    cyc();

    // randomized frames against the model
    for (int k = 0; k < 6; k++) begin
      if (m_state == 3) begin
        run_req = 1'b1;
        cyc();
        run_req = 1'b0;
      end
      if (m_state != 2) vs_edge();
      single_shot = 1'($urandom_range(1));
      kind = int'($urandom_range(3));
      n = (kind == 1) ? IMG - 1 - int'($urandom_range(300)) : IMG;
      frame(n, (kind == 3) ? 1 + int'($urandom_range(50)) : 0,
            ($urandom_range(1) == 1) ? int'($urandom_range(n - 1)) : -1,
            ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1,
            kind == 2);
    end
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
